// File: rtl/iter_shift_ctrl.sv
// iter_shift_ctrl: multi-cycle operand-2 shifter moving at most STEP
// bits per cycle between decode and the EXE ALU Val2 input.
// Ports: clk, rst (async, active-high)
//   request : in_valid, in_ready, shift_type, shift_amt, operand, carry_in
//   result  : out_valid, out_ready, result, carry_out
// Option: define ITER_SHIFT_CARRY_OUT_EN to build the carry-out path;
//   otherwise carry_out is tied 0 and carry_in is ignored.
module iter_shift_ctrl #(
  parameter int DATA_W = 32,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        shift_type,
  input  logic [4:0]        shift_amt,
  input  logic [DATA_W-1:0] operand,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [4:0] STEP_L = 5'(STEP);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] work_q, work_d, sh;
  logic [4:0]        rem_q, rem_d, k;
  logic [1:0]        type_q, type_d;
  logic [5:0]        rk;

  // Bits moved this cycle, and the complementary amount for ROR wrap.
  always_comb begin
    k  = (rem_q < STEP_L) ? rem_q : STEP_L;
    rk = 6'd32 - {1'b0, k};
  end

  // ASR keeps the working MSB, which is the latched operand[31].
  always_comb begin
    sh = '0;
    unique case (type_q)
      2'd0: sh = work_q << k;
      2'd1: sh = work_q >> k;
      2'd2: sh = DATA_W'($signed(work_q) >>> k);
      2'd3: sh = (work_q >> k) | (work_q << rk);
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    type_d  = type_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = operand;
          rem_d   = shift_amt;
          type_d  = shift_type;
          state_d = (shift_amt == 5'd0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        work_d = sh;
        rem_d  = rem_q - k;
        if (rem_q == k) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE);
  assign result    = work_q;

`ifdef ITER_SHIFT_CARRY_OUT_EN
  logic c_sh, carry_q, carry_d;

  // Last bit leaving the register on this step.
  always_comb begin
    c_sh = 1'b0;
    unique case (type_q)
      2'd0: c_sh = work_q[rk[4:0]];
      2'd1: c_sh = work_q[k - 5'd1];
      2'd2: c_sh = work_q[k - 5'd1];
      2'd3: c_sh = sh[DATA_W-1];
    endcase
  end

  always_comb begin
    carry_d = carry_q;
    if (state_q == IDLE && in_valid) carry_d = carry_in;
    else if (state_q == BUSY) carry_d = c_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) carry_q <= 1'b0;
    else     carry_q <= carry_d;
  end

  assign carry_out = carry_q;
`else
  logic unused_cin;
  assign unused_cin = carry_in;
  assign carry_out  = 1'b0;
`endif

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// tb_iter_shift_ctrl: directed and random checks of iter_shift_ctrl
// against a one-shot shift reference model.
module tb_iter_shift_ctrl;

`ifdef ITER_SHIFT_CARRY_OUT_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  shift_type = '0;
  logic [4:0]  shift_amt = '0;
  logic [31:0] operand = '0;
  logic        carry_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        carry_out;

  int checks = 0;
  int errors = 0;

  iter_shift_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .shift_type (shift_type),
    .shift_amt  (shift_amt),
    .operand    (operand),
    .carry_in   (carry_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry_out  (carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_shift(input logic [1:0] t, input int a,
                           input logic [31:0] op, input logic cin,
                           output logic [31:0] r, output logic c);
    c = cin;
    case (t)
      2'd0: begin
        r = op << a;
        if (a > 0) c = op[32 - a];
      end
      2'd1: begin
        r = op >> a;
        if (a > 0) c = op[a - 1];
      end
      2'd2: begin
        r = 32'($signed(op) >>> a);
        if (a > 0) c = op[a - 1];
      end
      default: begin
        r = (a == 0) ? op : ((op >> a) | (op << (32 - a)));
        if (a > 0) c = r[31];
      end
    endcase
    if (!CEN) c = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] t,
                       input int a, input logic [31:0] op,
                       input logic cin, input logic [31:0] er,
                       input logic ec, input int stall);
    int lat;
    @(negedge clk);
    out_ready  = (stall == 0);
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    shift_type = t;
    shift_amt  = 5'(a);
    operand    = op;
    carry_in   = cin;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    shift_type = 2'($urandom);
    shift_amt  = 5'($urandom);
    operand    = $urandom;
    carry_in   = 1'($urandom);
    wait_valid(lat);
    chk({tag, ".lat"}, 32'(lat), 32'(1 + (a + 3) / 4));
    chk({tag, ".res"}, result, er);
    chk({tag, ".cy"}, 32'(carry_out), 32'(ec));
    chk({tag, ".nrdy"}, 32'(in_ready), 32'd0);
    repeat (stall) begin
      @(posedge clk); #1;
      chk({tag, ".hold"}, result, er);
      chk({tag, ".hv"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".hs"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] er;
    logic        ec;
    int          lat;

    #1;
    chk("rst.ov", 32'(out_valid), 32'd0);
    chk("rst.res", result, 32'd0);
    chk("rst.cy", 32'(carry_out), 32'd0);
    chk("rst.rdy", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op("t1", 2'd0, 4, 32'h0000_00F1, 1'b0,
          32'h0000_0F10, 1'b0, 0);
    do_op("t2", 2'd2, 31, 32'h8000_0000, 1'b0,
          32'hFFFF_FFFF, 1'b0, 0);
    do_op("t3a", 2'd3, 1, 32'h0000_0001, 1'b0,
          32'h8000_0000, CEN, 0);
    do_op("t3b", 2'd1, 5, 32'h0000_00F0, 1'b0,
          32'h0000_0007, CEN, 0);
    do_op("t4", 2'd1, 0, 32'h1234_5678, 1'b1,
          32'h1234_5678, CEN, 0);

    // Stall in DONE with a second request pending.
    @(negedge clk);
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    shift_type = 2'd0;
    shift_amt  = 5'd4;
    operand    = 32'h0000_00F1;
    @(posedge clk); #1;
    shift_type = 2'd1;
    shift_amt  = 5'd5;
    operand    = 32'h0000_00F0;
    carry_in   = 1'b0;
    wait_valid(lat);
    chk("t5.lat", 32'(lat), 32'd2);
    repeat (5) begin
      @(posedge clk); #1;
      chk("t5.hold", result, 32'h0000_0F10);
      chk("t5.nrdy", 32'(in_ready), 32'd0);
      chk("t5.ov", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5.hs", 32'(out_valid), 32'd0);
    chk("t5.nottaken", result, 32'h0000_0F10);
    chk("t5.rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    chk("t5.lat2", 32'(lat), 32'd3);
    chk("t5.res2", result, 32'h0000_0007);
    chk("t5.cy2", 32'(carry_out), 32'(CEN));
    @(posedge clk); #1;

    // Reset mid-operation.
    @(negedge clk);
    in_valid   = 1'b1;
    shift_type = 2'd2;
    shift_amt  = 5'd31;
    operand    = 32'h8000_0000;
    carry_in   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6.ov", 32'(out_valid), 32'd0);
    chk("t6.res", result, 32'd0);
    chk("t6.cy", 32'(carry_out), 32'd0);
    chk("t6.rdy0", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6.rdy1", 32'(in_ready), 32'd1);
    repeat (12) begin
      @(posedge clk); #1;
      chk("t6.noreplay", 32'(out_valid), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  t;
      int          a;
      logic [31:0] op;
      logic        cin;
      t   = 2'($urandom);
      a   = $urandom_range(0, 31);
      op  = $urandom;
      cin = 1'($urandom);
      ref_shift(t, a, op, cin, er, ec);
      do_op($sformatf("r%0d", i), t, a, op, cin, er, ec,
            $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
